axi_rr_arbiter: RTL and testbench

- Parametrised N-port AXI4 arbiter. Generalises the fixed two-port, fetch-plus-LSU arbiter in the NPC top.
- Merges N single-beat requesters (IFU, LSU, DMA, ...) onto one AXI4 master port, io_master side.
- Read and write paths are arbitrated independently with rotating (round-robin) priority, so a read and a write may be outstanding concurrently.
- Transaction ID carries the granted port index.

---
 rtl/axi_rr_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_axi_rr_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter.sv
// N-port single-beat AXI4 arbiter: independent round-robin read and write paths
// merged onto one AXI4 master port; the transaction ID carries the granted port.
module axi_rr_arbiter #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ID_W    = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    // requester read address / data
    input  logic [N_PORTS-1:0]           s_arvalid,
    output logic [N_PORTS-1:0]           s_arready,
    input  logic [N_PORTS*ADDR_W-1:0]    s_araddr,
    input  logic [N_PORTS*3-1:0]         s_arsize,
    output logic [N_PORTS-1:0]           s_rvalid,
    input  logic [N_PORTS-1:0]           s_rready,
    output logic [DATA_W-1:0]            s_rdata,
    output logic [1:0]                   s_rresp,
    // requester write address / data / response
    input  logic [N_PORTS-1:0]           s_awvalid,
    output logic [N_PORTS-1:0]           s_awready,
    input  logic [N_PORTS*ADDR_W-1:0]    s_awaddr,
    input  logic [N_PORTS*3-1:0]         s_awsize,
    input  logic [N_PORTS-1:0]           s_wvalid,
    output logic [N_PORTS-1:0]           s_wready,
    input  logic [N_PORTS*DATA_W-1:0]    s_wdata,
    input  logic [N_PORTS*DATA_W/8-1:0]  s_wstrb,
    output logic [N_PORTS-1:0]           s_bvalid,
    input  logic [N_PORTS-1:0]           s_bready,
    output logic [1:0]                   s_bresp,
    // master AR
    output logic                         m_arvalid,
    input  logic                         m_arready,
    output logic [ID_W-1:0]              m_arid,
    output logic [ADDR_W-1:0]            m_araddr,
    output logic [7:0]                   m_arlen,
    output logic [2:0]                   m_arsize,
    output logic [1:0]                   m_arburst,
    // master R
    input  logic                         m_rvalid,
    output logic                         m_rready,
    input  logic [ID_W-1:0]              m_rid,
    input  logic [DATA_W-1:0]            m_rdata,
    input  logic [1:0]                   m_rresp,
    input  logic                         m_rlast,
    // master AW
    output logic                         m_awvalid,
    input  logic                         m_awready,
    output logic [ID_W-1:0]              m_awid,
    output logic [ADDR_W-1:0]            m_awaddr,
    output logic [7:0]                   m_awlen,
    output logic [2:0]                   m_awsize,
    output logic [1:0]                   m_awburst,
    // master W
    output logic                         m_wvalid,
    input  logic                         m_wready,
    output logic [DATA_W-1:0]            m_wdata,
    output logic [DATA_W/8-1:0]          m_wstrb,
    output logic                         m_wlast,
    // master B
    input  logic                         m_bvalid,
    output logic                         m_bready,
    input  logic [ID_W-1:0]              m_bid,
    input  logic [1:0]                   m_bresp
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned GW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_e;

    r_state_e        r_state_q, r_state_d;
    w_state_e        w_state_q, w_state_d;
    logic [GW-1:0]   r_grant_q, r_grant_d;
    logic [GW-1:0]   w_grant_q, w_grant_d;
    logic [GW-1:0]   rr_ptr_r_q, rr_ptr_r_d;
    logic [GW-1:0]   rr_ptr_w_q, rr_ptr_w_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;

    logic [ADDR_W-1:0] araddr_a [N_PORTS];
    logic [2:0]        arsize_a [N_PORTS];
    logic [ADDR_W-1:0] awaddr_a [N_PORTS];
    logic [2:0]        awsize_a [N_PORTS];
    logic [DATA_W-1:0] wdata_a  [N_PORTS];
    logic [STRB_W-1:0] wstrb_a  [N_PORTS];

    // Unpack the flat per-port payload buses into indexable arrays.
    for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
        assign araddr_a[i] = s_araddr[i*ADDR_W +: ADDR_W];
        assign arsize_a[i] = s_arsize[i*3 +: 3];
        assign awaddr_a[i] = s_awaddr[i*ADDR_W +: ADDR_W];
        assign awsize_a[i] = s_awsize[i*3 +: 3];
        assign wdata_a[i]  = s_wdata[i*DATA_W +: DATA_W];
        assign wstrb_a[i]  = s_wstrb[i*STRB_W +: STRB_W];
    end

    // First requesting port at or above ptr, wrapping around.
    function automatic logic [GW-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                              input logic [GW-1:0]      ptr);
        logic [GW-1:0] pick;
        logic [GW-1:0] idx_g;
        logic          found;
        int unsigned   idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned off = 0; off < N_PORTS; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            idx_g = GW'(idx);
            if (!found && req[idx_g]) begin
                pick  = idx_g;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [GW-1:0] next_port(input logic [GW-1:0] g);
        return (g == GW'(N_PORTS - 1)) ? '0 : g + GW'(1);
    endfunction

    // State registers for both paths.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state_q  <= R_IDLE;
            w_state_q  <= W_IDLE;
            r_grant_q  <= '0;
            w_grant_q  <= '0;
            rr_ptr_r_q <= '0;
            rr_ptr_w_q <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            w_state_q  <= w_state_d;
            r_grant_q  <= r_grant_d;
            w_grant_q  <= w_grant_d;
            rr_ptr_r_q <= rr_ptr_r_d;
            rr_ptr_w_q <= rr_ptr_w_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // Read path: grant, address phase, data phase routed back to the grantee.
    always_comb begin
        r_state_d  = r_state_q;
        r_grant_d  = r_grant_q;
        rr_ptr_r_d = rr_ptr_r_q;
        s_arready  = '0;
        s_rvalid   = '0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (|s_arvalid) begin
                    r_grant_d = rr_pick(s_arvalid, rr_ptr_r_q);
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                m_arvalid            = 1'b1;
                s_arready[r_grant_q] = m_arready;
                if (m_arready) r_state_d = R_DATA;
            end
            R_DATA: begin
                s_rvalid[r_grant_q] = m_rvalid;
                m_rready            = s_rready[r_grant_q];
                if (m_rvalid && s_rready[r_grant_q] && m_rlast) begin
                    r_state_d  = R_IDLE;
                    rr_ptr_r_d = next_port(r_grant_q);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    logic aw_hs;
    logic w_hs;

    // Write path: AW and W complete independently, then wait for B.
    always_comb begin
        w_state_d  = w_state_q;
        w_grant_d  = w_grant_q;
        rr_ptr_w_d = rr_ptr_w_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        s_awready  = '0;
        s_wready   = '0;
        s_bvalid   = '0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (|s_awvalid) begin
                    w_grant_d = rr_pick(s_awvalid, rr_ptr_w_q);
                    w_state_d = W_XFER;
                end
            end
            W_XFER: begin
                m_awvalid = !aw_done_q;
                m_wvalid  = !w_done_q && s_wvalid[w_grant_q];
                s_awready[w_grant_q] = m_awready && !aw_done_q;
                s_wready[w_grant_q]  = m_wready && !w_done_q;
                aw_hs     = m_awvalid && m_awready;
                w_hs      = m_wvalid && m_wready;
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) w_state_d = W_RESP;
            end
            W_RESP: begin
                s_bvalid[w_grant_q] = m_bvalid;
                m_bready            = s_bready[w_grant_q];
                if (m_bvalid && s_bready[w_grant_q]) begin
                    w_state_d  = W_IDLE;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    rr_ptr_w_d = next_port(w_grant_q);
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Payload muxes follow the registered grants.
    assign m_arid    = ID_W'(r_grant_q);
    assign m_araddr  = araddr_a[r_grant_q];
    assign m_arsize  = arsize_a[r_grant_q];
    assign m_awid    = ID_W'(w_grant_q);
    assign m_awaddr  = awaddr_a[w_grant_q];
    assign m_awsize  = awsize_a[w_grant_q];
    assign m_wdata   = wdata_a[w_grant_q];
    assign m_wstrb   = wstrb_a[w_grant_q];

    assign m_arlen   = 8'd0;
    assign m_awlen   = 8'd0;
    assign m_arburst = 2'b01;
    assign m_awburst = 2'b01;
    assign m_wlast   = 1'b1;

    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_bresp   = m_bresp;

    // Responses are routed by the held grant, so returned IDs are not needed.
    logic unused_ids;
    assign unused_ids = ^{m_rid, m_bid};

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed self-checking bench for axi_rr_arbiter with three requester ports.
module tb_axi_rr_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 4;

    logic              clock, reset;
    logic [N-1:0]      s_arvalid, s_arready, s_rvalid, s_rready;
    logic [N*AW-1:0]   s_araddr, s_awaddr;
    logic [N*3-1:0]    s_arsize, s_awsize;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp, s_bresp;
    logic [N-1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [N*DW-1:0]   s_wdata;
    logic [N*DW/8-1:0] s_wstrb;
    logic              m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [IW-1:0]     m_arid, m_rid, m_awid, m_bid;
    logic [AW-1:0]     m_araddr, m_awaddr;
    logic [7:0]        m_arlen, m_awlen;
    logic [2:0]        m_arsize, m_awsize;
    logic [1:0]        m_arburst, m_awburst, m_rresp, m_bresp;
    logic [DW-1:0]     m_rdata, m_wdata;
    logic              m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
    logic [DW/8-1:0]   m_wstrb;
    logic              m_bvalid, m_bready;

    int tests_run;
    int tests_failed;

    axi_rr_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clock(clock), .reset(reset),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arsize(s_arsize),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awsize(s_awsize),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_inputs();
        s_arvalid = '0; s_araddr = '0; s_arsize = '0; s_rready = '0;
        s_awvalid = '0; s_awaddr = '0; s_awsize = '0;
        s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_bready = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        s_arvalid = 3'b111; s_awvalid = 3'b111; s_wvalid = 3'b111;
        m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1; m_rvalid = 1'b1; m_bvalid = 1'b1;
        s_rready = 3'b111; s_bready = 3'b111;
        @(negedge clock); @(negedge clock); #1;
        tests_run++; if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 5'b0) begin
            tests_failed++; $display("FAIL reset_m_valid_ready: got %b expected 00000", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}); end
        tests_run++; if ({s_arready, s_rvalid, s_awready, s_wready, s_bvalid} !== 15'b0) begin
            tests_failed++; $display("FAIL reset_s_valid_ready: got %b expected 0", {s_arready, s_rvalid, s_awready, s_wready, s_bvalid}); end
        tests_run++; if ({m_arlen, m_awlen, m_arburst, m_awburst, m_wlast} !== {8'd0, 8'd0, 2'b01, 2'b01, 1'b1}) begin
            tests_failed++; $display("FAIL const_outputs: got %h expected %h", {m_arlen, m_awlen, m_arburst, m_awburst, m_wlast}, {8'd0, 8'd0, 2'b01, 2'b01, 1'b1}); end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        s_arvalid = 3'b010; s_araddr[AW +: AW] = 32'h8000_0010; s_arsize[3 +: 3] = 3'd2;
        m_arready = 1'b1; #1;
        tests_run++; if (m_arvalid !== 1'b0) begin
            tests_failed++; $display("FAIL rd_latency: got %b expected 0", m_arvalid); end
        @(negedge clock); #1;
        tests_run++; if ({m_arvalid, m_arid} !== {1'b1, 4'd1}) begin
            tests_failed++; $display("FAIL rd_ar_id: got %h expected %h", {m_arvalid, m_arid}, {1'b1, 4'd1}); end
        tests_run++; if ({m_araddr, m_arsize} !== {32'h8000_0010, 3'd2}) begin
            tests_failed++; $display("FAIL rd_ar_payload: got %h expected %h", {m_araddr, m_arsize}, {32'h8000_0010, 3'd2}); end
        tests_run++; if (s_arready !== 3'b010) begin
            tests_failed++; $display("FAIL rd_arready: got %b expected 010", s_arready); end
        @(negedge clock);
        s_arvalid = '0; m_arready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00; m_rlast = 1'b1; s_rready = 3'b010; #1;
        tests_run++; if ({s_rvalid, m_rready} !== {3'b010, 1'b1}) begin
            tests_failed++; $display("FAIL rd_rvalid_route: got %b expected 0101", {s_rvalid, m_rready}); end
        tests_run++; if ({s_rdata, s_rresp} !== {32'hDEAD_BEEF, 2'b00}) begin
            tests_failed++; $display("FAIL rd_rdata: got %h expected %h", {s_rdata, s_rresp}, {32'hDEAD_BEEF, 2'b00}); end
        @(negedge clock);
        m_rvalid = 1'b0; s_rready = '0; #1;
        tests_run++; if ({s_rvalid, m_arvalid} !== 4'b0) begin
            tests_failed++; $display("FAIL rd_back_idle: got %b expected 0000", {s_rvalid, m_arvalid}); end
    endtask

    task automatic test_round_robin();
        logic [IW-1:0] exp_id;
        logic [N-1:0]  exp_oh;
        int            n;
        do_reset();
        s_arvalid = 3'b111; m_arready = 1'b1;
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'h1111_2222; s_rready = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_id = IW'(k % 3);
            exp_oh = 3'b001 << (k % 3);
            n = 0; #1;
            while (m_arvalid !== 1'b1 && n < 10) begin
                @(negedge clock); #1; n++;
            end
            tests_run++; if ({m_arvalid, m_arid} !== {1'b1, exp_id}) begin
                tests_failed++; $display("FAIL rr_grant_%0d: got %h expected %h", k, {m_arvalid, m_arid}, {1'b1, exp_id}); end
            @(negedge clock); #1;
            tests_run++; if (s_rvalid !== exp_oh) begin
                tests_failed++; $display("FAIL rr_rvalid_%0d: got %b expected %b", k, s_rvalid, exp_oh); end
        end
        do_reset();
    endtask

    task automatic test_concurrent();
        do_reset();
        s_arvalid = 3'b001; s_araddr[0 +: AW] = 32'h100;
        s_awvalid = 3'b010; s_awaddr[AW +: AW] = 32'h200;
        s_wvalid = 3'b010; s_wdata[DW +: DW] = 32'hCAFE; s_wstrb[4 +: 4] = 4'hF;
        m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        @(negedge clock); #1;
        tests_run++; if ({m_arvalid, m_arid, m_araddr} !== {1'b1, 4'd0, 32'h100}) begin
            tests_failed++; $display("FAIL cc_ar: got %h expected %h", {m_arvalid, m_arid, m_araddr}, {1'b1, 4'd0, 32'h100}); end
        tests_run++; if ({m_awvalid, m_awid, m_awaddr} !== {1'b1, 4'd1, 32'h200}) begin
            tests_failed++; $display("FAIL cc_aw: got %h expected %h", {m_awvalid, m_awid, m_awaddr}, {1'b1, 4'd1, 32'h200}); end
        tests_run++; if ({m_wvalid, m_wdata, m_wstrb} !== {1'b1, 32'hCAFE, 4'hF}) begin
            tests_failed++; $display("FAIL cc_w: got %h expected %h", {m_wvalid, m_wdata, m_wstrb}, {1'b1, 32'hCAFE, 4'hF}); end
        tests_run++; if ({s_arready, s_awready, s_wready} !== {3'b001, 3'b010, 3'b010}) begin
            tests_failed++; $display("FAIL cc_readies: got %b expected 001010010", {s_arready, s_awready, s_wready}); end
        @(negedge clock);
        s_arvalid = '0; s_awvalid = '0; s_wvalid = '0;
        m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h1234; m_rlast = 1'b1; s_rready = 3'b001;
        m_bvalid = 1'b1; m_bresp = 2'b01; s_bready = 3'b010; #1;
        tests_run++; if ({s_rvalid, s_bvalid, m_rready, m_bready} !== {3'b001, 3'b010, 2'b11}) begin
            tests_failed++; $display("FAIL cc_resp_route: got %b expected 00101011", {s_rvalid, s_bvalid, m_rready, m_bready}); end
        tests_run++; if ({s_bresp, s_rdata, m_awvalid, m_wvalid} !== {2'b01, 32'h1234, 2'b00}) begin
            tests_failed++; $display("FAIL cc_resp_data: got %h expected %h", {s_bresp, s_rdata, m_awvalid, m_wvalid}, {2'b01, 32'h1234, 2'b00}); end
        @(negedge clock);
        clear_inputs(); #1;
        tests_run++; if ({s_rvalid, s_bvalid, m_arvalid, m_awvalid} !== 8'b0) begin
            tests_failed++; $display("FAIL cc_idle: got %b expected 0", {s_rvalid, s_bvalid, m_arvalid, m_awvalid}); end
    endtask

    // mode 0: W before AW, 1: AW before W, 2: same cycle
    task automatic test_aw_w_order(input int mode);
        logic [N-1:0] exp_awr, exp_wr;
        s_awvalid = 3'b100; s_wvalid = 3'b100;
        s_awaddr[2*AW +: AW] = 32'h300 + 32'(mode); s_wdata[2*DW +: DW] = 32'(mode);
        m_bvalid = 1'b1; s_bready = 3'b100; m_awready = 1'b0; m_wready = 1'b0;
        @(negedge clock);
        m_awready = (mode != 0); m_wready = (mode != 1); #1;
        tests_run++; if ({m_awvalid, m_wvalid, m_awid, s_bvalid, m_bready} !== {2'b11, 4'd2, 3'b000, 1'b0}) begin
            tests_failed++; $display("FAIL ord%0d_first: got %b expected %b", mode, {m_awvalid, m_wvalid, m_awid, s_bvalid, m_bready}, {2'b11, 4'd2, 3'b000, 1'b0}); end
        if (mode != 2) begin
            @(negedge clock);
            m_awready = 1'b1; m_wready = 1'b1; #1;
            exp_awr = (mode == 0) ? 3'b100 : 3'b000;
            exp_wr  = (mode == 1) ? 3'b100 : 3'b000;
            tests_run++; if ({m_awvalid, m_wvalid, s_awready, s_wready, s_bvalid} !== {mode == 0, mode == 1, exp_awr, exp_wr, 3'b000}) begin
                tests_failed++; $display("FAIL ord%0d_second: got %b expected %b", mode, {m_awvalid, m_wvalid, s_awready, s_wready, s_bvalid}, {mode == 0, mode == 1, exp_awr, exp_wr, 3'b000}); end
        end
        @(negedge clock);
        m_awready = 1'b0; m_wready = 1'b0; s_awvalid = '0; s_wvalid = '0; #1;
        tests_run++; if ({m_awvalid, m_wvalid, s_bvalid, m_bready} !== {2'b00, 3'b100, 1'b1}) begin
            tests_failed++; $display("FAIL ord%0d_resp: got %b expected 001001", mode, {m_awvalid, m_wvalid, s_bvalid, m_bready}); end
        @(negedge clock);
        m_bvalid = 1'b0; s_bready = '0; #1;
        tests_run++; if ({s_bvalid, m_awvalid} !== 4'b0) begin
            tests_failed++; $display("FAIL ord%0d_idle: got %b expected 0000", mode, {s_bvalid, m_awvalid}); end
    endtask

    task automatic test_error_resp();
        do_reset();
        s_arvalid = 3'b001; s_araddr[0 +: AW] = 32'h40; m_arready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        s_arvalid = '0; m_arready = 1'b0;
        m_rvalid = 1'b1; m_rresp = 2'b10; m_rlast = 1'b1; m_rdata = 32'hBAD; s_rready = 3'b001; #1;
        tests_run++; if ({s_rvalid, s_rresp} !== {3'b001, 2'b10}) begin
            tests_failed++; $display("FAIL err_rresp: got %b expected 00110", {s_rvalid, s_rresp}); end
        @(negedge clock);
        m_rvalid = 1'b0; s_rready = '0; s_arvalid = 3'b011; #1;
        tests_run++; if ({m_arvalid, s_rvalid} !== 4'b0) begin
            tests_failed++; $display("FAIL err_idle: got %b expected 0000", {m_arvalid, s_rvalid}); end
        @(negedge clock); #1;
        tests_run++; if ({m_arvalid, m_arid} !== {1'b1, 4'd1}) begin
            tests_failed++; $display("FAIL err_next_grant: got %h expected %h", {m_arvalid, m_arid}, {1'b1, 4'd1}); end
        do_reset();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        s_arvalid = 3'b010; s_araddr[AW +: AW] = 32'h500; m_arready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        s_arvalid = '0; m_arready = 1'b0;
        m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = 32'h5555; s_rready = '0; #1;
        tests_run++; if (s_rvalid !== 3'b010) begin
            tests_failed++; $display("FAIL rst_pending: got %b expected 010", s_rvalid); end
        reset = 1'b0;
        @(negedge clock); #1;
        tests_run++; if ({s_rvalid, m_rready, m_arvalid} !== 5'b0) begin
            tests_failed++; $display("FAIL rst_abandon: got %b expected 00000", {s_rvalid, m_rready, m_arvalid}); end
        reset = 1'b1; s_rready = 3'b111;
        @(negedge clock); #1;
        tests_run++; if ({s_rvalid, m_rready} !== 4'b0) begin
            tests_failed++; $display("FAIL rst_stale_beat: got %b expected 0000", {s_rvalid, m_rready}); end
        m_rvalid = 1'b0; s_rready = '0; s_arvalid = 3'b111;
        @(negedge clock); #1;
        tests_run++; if ({m_arvalid, m_arid} !== {1'b1, 4'd0}) begin
            tests_failed++; $display("FAIL rst_ptr_zero: got %h expected %h", {m_arvalid, m_arid}, {1'b1, 4'd0}); end
        do_reset();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_concurrent();
        do_reset();
        for (int m = 0; m < 3; m++) test_aw_w_order(m);
        test_error_resp();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
